// File: rtl/blockmem2p_pkg.sv
// Shared types for the dual-port block RAM helpers.
// Read-engine state encoding and the RAM address-width helper.
package blockmem2p_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rd_state_e;

    // A one-word RAM still needs a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/blockmem2p_rd_skid.sv
// Two-entry FIFO holding read data (plus its last flag) in front of
// the output stream; the head entry drives the stream outputs.
module blockmem2p_rd_skid
    import blockmem2p_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] data_q [2];
    logic [1:0]   last_q;
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   occ_q;
    logic         pop;

    assign valid_o = (occ_q != 2'd0);
    assign pop     = valid_o & ready_i;
    assign occ_o   = occ_q;
    assign data_o  = valid_o ? data_q[rd_q] : '0;
    assign last_o  = valid_o & last_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_q] <= data_i;
                last_q[wr_q] <= last_i;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/blockmem2p_reader.sv
// Command-driven burst reader on the RAM B port: issues enb/addrb and
// turns the registered read data into a valid/ready stream with last.
module blockmem2p_reader
    import blockmem2p_pkg::*;
#(
    parameter  int G_MEMWIDTH  = 32,
    parameter  int G_MEMDEPTH  = 1024,
    localparam int G_ADDRWIDTH = addr_width(G_MEMDEPTH),
    localparam int G_LENWIDTH  = G_ADDRWIDTH + 1
) (
    input  logic                   clkb,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [G_ADDRWIDTH-1:0] cmd_addr,
    input  logic [G_LENWIDTH-1:0]  cmd_len,
    output logic                   enb,
    output logic [G_ADDRWIDTH-1:0] addrb,
    input  logic [G_MEMWIDTH-1:0]  doutb,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [G_MEMWIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [G_ADDRWIDTH-1:0] LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);
    localparam logic [G_LENWIDTH-1:0]  ONE       = G_LENWIDTH'(1);

    rd_state_e              state_q, state_d;
    logic [G_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [G_LENWIDTH-1:0]  rem_q, rem_d;
    logic [G_LENWIDTH-1:0]  words_q, words_d;
    logic                   rd_pend_q;
    logic                   last_pend_q;
    logic [1:0]             occ;
    logic                   pop;
    logic                   credit_ok;

    assign pop   = m_valid & m_ready;
    assign addrb = addr_q;

    // Words already held plus the one in flight must leave room for the next.
    assign credit_ok = ({1'b0, occ} + {2'b0, rd_pend_q}) < (3'd2 + {2'b0, pop});

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        words_d   = words_q;
        enb       = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (pop) begin
            words_d = words_q - ONE;
        end
        unique case (state_q)
            IDLE: begin
                cmd_ready = rstn;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    words_d = cmd_len;
                    state_d = (cmd_len != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy = 1'b1;
                enb  = credit_ok && (rem_q != '0);
                if (enb) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && (words_q == ONE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            words_q     <= '0;
            rd_pend_q   <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            words_q     <= words_d;
            rd_pend_q   <= enb;
            last_pend_q <= enb && (rem_q == ONE);
        end
    end

    blockmem2p_rd_skid #(
        .W (G_MEMWIDTH)
    ) u_skid (
        .clk_i   (clkb),
        .rst_n_i (rstn),
        .push_i  (rd_pend_q),
        .data_i  (doutb),
        .last_i  (last_pend_q),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data),
        .last_o  (m_last),
        .occ_o   (occ)
    );

endmodule

// File: tb/tb_blockmem2p_reader.sv
// Directed bench for blockmem2p_reader with a behavioural RAM B port.
module tb_blockmem2p_reader;

    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clkb      = 1'b0;
    logic          rstn      = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr  = '0;
    logic [LW-1:0] cmd_len   = '0;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb     = '0;
    logic          m_valid;
    logic          m_ready   = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] ram [DEPTH];

    always #5 clkb = ~clkb;

    always @(posedge clkb) doutb <= enb ? ram[addrb] : '0;

    blockmem2p_reader #(
        .G_MEMWIDTH (DW),
        .G_MEMDEPTH (DEPTH)
    ) dut (
        .clkb      (clkb),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // Monitor: cycle c is the interval following the c-th rising edge.
    int            cyc = 0;
    int            en_addr [$];
    int            en_cyc [$];
    logic [DW-1:0] bt_data [$];
    logic          bt_last [$];
    int            bt_cyc [$];
    int            done_cyc [$];
    int            hs_cyc, first_v, rdy_cyc, stab_err, max_occ;
    logic          pv_stall = 1'b0;
    logic [DW-1:0] pv_data;
    logic          pv_last;

    always @(posedge clkb) cyc <= cyc + 1;

    always @(negedge clkb) begin
        if (enb) begin
            en_addr.push_back(int'(addrb));
            en_cyc.push_back(cyc);
        end
        if (m_valid && first_v < 0) first_v = cyc;
        if (m_valid && m_ready) begin
            bt_data.push_back(m_data);
            bt_last.push_back(m_last);
            bt_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (cmd_valid && cmd_ready) hs_cyc = cyc;
        if (cmd_ready && hs_cyc >= 0 && cyc > hs_cyc && rdy_cyc < 0) rdy_cyc = cyc;
        if (pv_stall && (!m_valid || m_data !== pv_data || m_last !== pv_last))
            stab_err++;
        pv_stall = m_valid && !m_ready;
        pv_data  = m_data;
        pv_last  = m_last;
        if (int'(dut.u_skid.occ_o) > max_occ) max_occ = int'(dut.u_skid.occ_o);
    end

    task automatic tick();
        @(posedge clkb);
        #1;
    endtask

    task automatic clear_mon();
        en_addr.delete();
        en_cyc.delete();
        bt_data.delete();
        bt_last.delete();
        bt_cyc.delete();
        done_cyc.delete();
        hs_cyc   = -1;
        first_v  = -1;
        rdy_cyc  = -1;
        stab_err = 0;
        max_occ  = 0;
    endtask

    task automatic send_cmd(input int a, input int l);
        logic ok;
        ok        = 1'b0;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(l);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd addr=%0d len=%0d not accepted in 20 cycles", a, l);
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        n_chk++;
        if (done_cyc.size() == 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic check_beats(input string nm, input int base, input int n);
        logic [DW-1:0] got;
        logic          gl;
        n_chk++;
        if (bt_data.size() != n) begin
            n_fail++;
            $display("FAIL %s_count: beats=%0d want %0d", nm, bt_data.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            got = (i < bt_data.size()) ? bt_data[i] : 32'hDEAD_BEEF;
            gl  = (i < bt_last.size()) ? bt_last[i] : 1'bx;
            n_chk++;
            if (got !== DW'((base + i) % DEPTH) || gl !== (i == n - 1)) begin
                n_fail++;
                $display("FAIL %s_beat%0d: data=%0h last=%b want data=%0h last=%b",
                         nm, i, got, gl, (base + i) % DEPTH, (i == n - 1));
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({cmd_ready, enb, m_valid, m_last, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rdy,enb,v,last,busy,done=%b want 000000",
                     {cmd_ready, enb, m_valid, m_last, busy, done});
        end
        n_chk++;
        if (m_data !== '0 || addrb !== '0) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%0h addrb=%0d want 0 0", m_data, addrb);
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        n_chk++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        clear_mon();
        m_ready = 1'b1;
        send_cmd(5, 1);
        wait_done(20);
        tick();
        n_chk++;
        if (en_addr.size() != 1 || en_addr[0] != 5 || en_cyc[0] != hs_cyc + 1) begin
            n_fail++;
            $display("FAIL single_enb: count=%0d want 1 addr 5 one cycle after handshake",
                     en_addr.size());
        end
        n_chk++;
        if (first_v != hs_cyc + 3) begin
            n_fail++;
            $display("FAIL single_latency: first valid cycle=%0d want %0d", first_v, hs_cyc + 3);
        end
        n_chk++;
        if (bt_data.size() != 1 || bt_data[0] !== 32'hA5A5_0005 || bt_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat: beats=%0d want 1 of a5a50005 with last", bt_data.size());
        end
        n_chk++;
        if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc + 4) begin
            n_fail++;
            $display("FAIL single_done: done pulses=%0d want 1 at cycle %0d",
                     done_cyc.size(), hs_cyc + 4);
        end
    endtask

    task automatic test_burst();
        int bad;
        clear_mon();
        ram[5] = 32'd5;
        m_ready = 1'b1;
        send_cmd(16, 4);
        wait_done(30);
        tick();
        check_beats("burst", 16, 4);
        bad = (en_addr.size() != 4) ? 1 : 0;
        for (int i = 0; i < en_addr.size() && i < 4; i++)
            if (en_addr[i] != 16 + i || en_cyc[i] != hs_cyc + 1 + i) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL burst_enb: %0d bad enb cycles, count=%0d want 4 contiguous 16..19",
                     bad, en_addr.size());
        end
        bad = 0;
        for (int i = 0; i < bt_cyc.size(); i++)
            if (bt_cyc[i] != hs_cyc + 3 + i) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL burst_rate: %0d beats off the 1-per-cycle slot, want 0", bad);
        end
    endtask

    task automatic test_stall();
        logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int   en_stall;
        clear_mon();
        m_ready = 1'b1;
        send_cmd(16, 4);
        for (int i = 0; i < 9; i++) begin
            m_ready = pat[i];
            tick();
        end
        m_ready = 1'b1;
        wait_done(40);
        tick();
        check_beats("stall", 16, 4);
        n_chk++;
        if (en_addr.size() != 4 || stab_err != 0 || max_occ > 2) begin
            n_fail++;
            $display("FAIL stall_integrity: reads=%0d unstable=%0d max_occ=%0d want 4 0 <=2",
                     en_addr.size(), stab_err, max_occ);
        end
        en_stall = 0;
        foreach (en_cyc[i])
            if (en_cyc[i] >= hs_cyc + 4 && en_cyc[i] <= hs_cyc + 9) en_stall++;
        n_chk++;
        if (en_stall != 0) begin
            n_fail++;
            $display("FAIL stall_credit: enb cycles while full=%0d want 0", en_stall);
        end
    endtask

    task automatic test_wrap();
        int exp_a [4] = '{1022, 1023, 0, 1};
        int bad;
        logic [DW-1:0] got;
        clear_mon();
        m_ready = 1'b1;
        send_cmd(1022, 4);
        wait_done(30);
        tick();
        bad = (en_addr.size() != 4) ? 1 : 0;
        for (int i = 0; i < en_addr.size() && i < 4; i++)
            if (en_addr[i] != exp_a[i]) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_addr: %0d bad addresses of %0d want 1022,1023,0,1",
                     bad, en_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < bt_data.size()) ? bt_data[i] : 32'hDEAD_BEEF;
            n_chk++;
            if (got !== DW'(exp_a[i])) begin
                n_fail++;
                $display("FAIL wrap_data%0d: data=%0h want %0h", i, got, exp_a[i]);
            end
        end
    endtask

    task automatic test_len0();
        clear_mon();
        m_ready = 1'b1;
        send_cmd(7, 0);
        tick();
        tick();
        n_chk++;
        if (en_addr.size() != 0 || first_v >= 0) begin
            n_fail++;
            $display("FAIL len0_idle: reads=%0d valid_seen=%0d want 0 -1", en_addr.size(), first_v);
        end
        n_chk++;
        if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc + 1) begin
            n_fail++;
            $display("FAIL len0_done: pulses=%0d want 1 at cycle %0d", done_cyc.size(), hs_cyc + 1);
        end
        n_chk++;
        if (rdy_cyc != hs_cyc + 2) begin
            n_fail++;
            $display("FAIL len0_ready: cmd_ready back at %0d want %0d", rdy_cyc, hs_cyc + 2);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_mon();
        m_ready = 1'b1;
        send_cmd(100, 8);
        k = 0;
        while (bt_data.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({m_valid, enb, busy, done, cmd_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: v,enb,busy,done,rdy=%b want 00000 (beats=%0d)",
                     {m_valid, enb, busy, done, cmd_ready}, bt_data.size());
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        n_chk++;
        if (done_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_nodone: done pulses=%0d want 0", done_cyc.size());
        end
        clear_mon();
        send_cmd(0, 2);
        wait_done(30);
        tick();
        check_beats("post_rst", 0, 2);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
        ram[5] = 32'hA5A5_0005;
        clear_mon();
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_wrap();
        test_len0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
